vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Generates 640x480@60 raster timing for the Chip-8 video path.
- Sits directly upstream of the display/playfield renderer and supplies its coordinate and strobe inputs: pixelX, pixelY, pixelEnable, lineStart and frameStart.
- Drives hsync/vsync to the VGA connector.
- Coordinates are 11-bit two's complement. The visible area is x 0..639, y 0..479. Blanking occupies negative coordinates, so downstream stages can pre-fetch at fixed negative x, e.g. a shifter load at x = -4.

Parameters:
- CLK_DIV, 2: clk cycles per pixel; must be >= 1 (50 MHz clk -> 25 MHz pixel rate).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk, input, 1: system clock.
- res, input, 1: reset, synchronous, active-high.
- pixelX, output, 11: current x, two's complement, range -(H_FP+H_SYNC+H_BP) .. H_ACTIVE-1.
- pixelY, output, 11: current y, two's complement, range -(V_FP+V_SYNC+V_BP) .. V_ACTIVE-1.
- pixelEnable, output, 1: one-clk strobe per visible pixel.
- lineStart, output, 1: one-clk strobe at the first pixel slot of every line.
- frameStart, output, 1: one-clk strobe at the first pixel slot of every frame.
- hsync, output, 1: horizontal sync, active low.
- vsync, output, 1: vertical sync, active low.
- vblank, output, 1: high while pixelY is negative.
- timerTick, output, 1: one-clk pulse per frame; see Optional Feature.

Behaviour:
- Interface: single clock clk. Reset res is synchronous and active-high. All state is registered on posedge clk.
- Definitions: HB = H_FP+H_SYNC+H_BP (default 160). VB = V_FP+V_SYNC+V_BP (default 45).
- Divider:
  - divCnt counts 0..CLK_DIV-1 and wraps.
  - tick = (divCnt == CLK_DIV-1).
  - With CLK_DIV = 1, tick is constantly high.
- Horizontal counter:
  - On tick: if pixelX == H_ACTIVE-1, pixelX <= -HB and the line advances; else pixelX <= pixelX + 1.
  - Arithmetic is 11-bit wrapping.
- Vertical counter:
  - Advances only on a tick at end of line.
  - If pixelY == V_ACTIVE-1, pixelY <= -VB; else pixelY <= pixelY + 1.
- Horizontal line order, in x:
  - Front porch: [-HB, -HB+H_FP).
  - Sync: [-HB+H_FP, -H_BP).
  - Back porch: [-H_BP, 0).
  - Active: [0, H_ACTIVE).
  - Default values: FP -160..-145, sync -144..-49, BP -48..-1.
- Vertical frame order, same scheme in y. Default values: FP -45..-36, sync -35..-34, BP -33..-1.
- Sync outputs:
  - hsync and vsync are registered.
  - They are updated in the same clk edge that loads the new pixelX/pixelY, so they are always consistent with the coordinate outputs (zero relative skew).
- Strobes are combinational decodes of registered state, valid in the clk cycle where tick = 1:
  - pixelEnable = tick & (pixelX >= 0) & (pixelY >= 0). It is never asserted in blanking.
  - lineStart = tick & (pixelX == -HB).
  - frameStart = lineStart & (pixelY == -VB). frameStart and lineStart are asserted together at frame start; the consumer gives frameStart priority.
- Each (x, y) position is held for exactly CLK_DIV clk cycles. Its strobe appears in the last of those cycles, and the counters advance on the following edge.
- vblank = pixelY[10], the sign bit.
- Reset: divCnt = 0, pixelX = -HB, pixelY = -VB, hsync = 1, vsync = 1, timerTick = 0.
  - First tick after reset: lineStart = frameStart = 1.
  - Reset asserted mid-line or mid-frame returns all state to these values on the next edge. No partial line is completed.
- Periods at defaults: 800 pixel slots per line, 525 lines per frame, 420000 pixel slots per frame. With CLK_DIV = 2 that is 840000 clk per frame.

Optional Feature:
- Macro: VGA_TIMER_TICK_EN.
- Defined: timerTick is a registered one-clk pulse on the edge after the tick where pixelX == -HB and pixelY == 0, i.e. the first active line. It gives one pulse per frame (~59.5 Hz at 25 MHz) for the Chip-8 delay and sound timers.
- Undefined: timerTick is constant 0 and no extra logic is built.

Test Plan:
- Reset, CLK_DIV=2: release res. First tick cycle (clk 1) shows pixelX = -160 (0x760), pixelY = -45 (0x7D3), and lineStart = frameStart = 1; hsync = vsync = 1.
- Line timing: count clk from lineStart to the next lineStart = 1600. hsync is low for exactly 192 clk, starting when pixelX = -144. pixelEnable pulses exactly 640 times per line on active lines and 0 times on blank lines.
- Frame timing: frameStart period = 840000 clk. vsync is low exactly while pixelY is -35 or -34 (2 lines, 3200 clk). vblank is high for 45 lines.
- Coordinate wrap: at pixelX = 639 on a tick, the next value is -160 and pixelY increments. At pixelY = 479 and pixelX = 639, the next values are -160 and -45. The next tick shows frameStart = 1.
- Pre-fetch point: pixelX = -4 (0x7FC) is held for exactly 2 clk on every line, and pixelEnable = 0 during it. CLK_DIV=1 variant: pixelEnable is high on 640 consecutive clk per active line.
- Mid-frame reset: assert res for 1 clk at pixelY = 200, pixelX = 300. The next edge restores the reset values, with no pixelEnable in between. With VGA_TIMER_TICK_EN, timerTick pulses once per frame 1 clk after the tick where pixelX = -160 and pixelY = 0; without it, timerTick stays 0.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing to the renderer and VGA connector.
// Coordinates are 11-bit two's complement; blanking lives at negative values.
interface vga_timing_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        pixelEnable;
  logic        lineStart;
  logic        frameStart;
  logic        hsync;
  logic        vsync;
  logic        vblank;
  logic        timerTick;

  modport master (
    output pixelX, pixelY, pixelEnable, lineStart, frameStart,
           hsync, vsync, vblank, timerTick
  );

  modport slave (
    input pixelX, pixelY, pixelEnable, lineStart, frameStart,
          hsync, vsync, vblank, timerTick
  );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster timing with signed coordinates, so blanking sits at negative x/y.
// Define VGA_TIMER_TICK_EN to build the once-per-frame timerTick pulse; otherwise it is tied low.
module vga_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic          clk,
  input logic          res,
  vga_timing_if.master vga
);
  localparam int HB    = H_FP + H_SYNC + H_BP;
  localparam int VB    = V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic signed [10:0] X_FIRST    = 11'(-HB);
  localparam logic signed [10:0] X_LAST     = 11'(H_ACTIVE - 1);
  localparam logic signed [10:0] X_SYNC_BEG = 11'(H_FP - HB);
  localparam logic signed [10:0] X_SYNC_END = 11'(-H_BP);
  localparam logic signed [10:0] Y_FIRST    = 11'(-VB);
  localparam logic signed [10:0] Y_LAST     = 11'(V_ACTIVE - 1);
  localparam logic signed [10:0] Y_SYNC_BEG = 11'(V_FP - VB);
  localparam logic signed [10:0] Y_SYNC_END = 11'(-V_BP);

  logic [DIV_W-1:0]   div_cnt;
  logic signed [10:0] pixel_x;
  logic signed [10:0] pixel_y;
  logic signed [10:0] x_next;
  logic signed [10:0] y_next;
  logic               tick;
  logic               line_end;
  logic               line_start;
  logic               hsync_q;
  logic               vsync_q;
  logic               hsync_next;
  logic               vsync_next;

  assign tick     = (div_cnt == DIV_LAST);
  assign line_end = tick && (pixel_x == X_LAST);

  always_comb begin
    // NOTE: defaults come first so every path assigns both outputs; a missing branch would infer a latch.
    x_next = pixel_x;
    y_next = pixel_y;
    if (tick) begin
      x_next = line_end ? X_FIRST : pixel_x + 11'sd1;
    end
    if (line_end) begin
      y_next = (pixel_y == Y_LAST) ? Y_FIRST : pixel_y + 11'sd1;
    end
  end

  // Sync levels are derived from the coordinates being loaded, so they change on the same edge.
  assign hsync_next = !((x_next >= X_SYNC_BEG) && (x_next < X_SYNC_END));
  assign vsync_next = !((y_next >= Y_SYNC_BEG) && (y_next < Y_SYNC_END));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (res) begin
      div_cnt <= '0;
      pixel_x <= X_FIRST;
      pixel_y <= Y_FIRST;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      pixel_x <= x_next;
      pixel_y <= y_next;
      hsync_q <= hsync_next;
      vsync_q <= vsync_next;
    end
  end

  assign line_start = tick && (pixel_x == X_FIRST);

  assign vga.pixelX      = pixel_x;
  assign vga.pixelY      = pixel_y;
  assign vga.pixelEnable = tick && !pixel_x[10] && !pixel_y[10];
  assign vga.lineStart   = line_start;
  assign vga.frameStart  = line_start && (pixel_y == Y_FIRST);
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.vblank      = pixel_y[10];

`ifdef VGA_TIMER_TICK_EN
  // Pulses once per frame, one clk after the first slot of the first visible line.
  logic timer_tick;

  always_ff @(posedge clk) begin
    if (res) begin
      timer_tick <= 1'b0;
    end else begin
      timer_tick <= line_start && (pixel_y == 11'sd0);
    end
  end

  assign vga.timerTick = timer_tick;
`else
  assign vga.timerTick = 1'b0;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-geometry instance (CLK_DIV=2) and a shrunken CLK_DIV=1 instance,
// both checked against a closed-form model derived from the cycle count since reset.
`timescale 1ns/1ps
module tb_vga_timing;
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        pe;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        vb;
    logic        tt;
  } obs_t;

  typedef struct packed {
    int div; int ha; int hfp; int hsw; int hbp; int va; int vfp; int vsw; int vbp;
  } geom_t;

  localparam int B_DIV = 1;
  localparam int B_HA  = 12;
  localparam int B_HFP = 2;
  localparam int B_HS  = 3;
  localparam int B_HBP = 4;
  localparam int B_VA  = 5;
  localparam int B_VFP = 2;
  localparam int B_VS  = 2;
  localparam int B_VBP = 3;
  localparam int B_HT  = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_VT  = B_VA + B_VFP + B_VS + B_VBP;
  localparam int B_FRAME = B_HT * B_VT;

`ifdef VGA_TIMER_TICK_EN
  localparam int TT_PER_FRAME = 1;
`else
  localparam int TT_PER_FRAME = 0;
`endif

  logic  clk   = 1'b0;
  logic  res_a = 1'b1;
  logic  res_b = 1'b1;
  int    na = 0;
  int    nb = 0;
  int    checks = 0;
  int    failures = 0;
  geom_t ga;
  geom_t gb;
  obs_t  got_a;
  obs_t  got_b;

  vga_timing_if a_if ();
  vga_timing_if b_if ();

  vga_timing dut_a (.clk(clk), .res(res_a), .vga(a_if));

  vga_timing #(
    .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)
  ) dut_b (.clk(clk), .res(res_b), .vga(b_if));

  assign got_a = {a_if.pixelX, a_if.pixelY, a_if.pixelEnable, a_if.lineStart, a_if.frameStart,
                  a_if.hsync, a_if.vsync, a_if.vblank, a_if.timerTick};
  assign got_b = {b_if.pixelX, b_if.pixelY, b_if.pixelEnable, b_if.lineStart, b_if.frameStart,
                  b_if.hsync, b_if.vsync, b_if.vblank, b_if.timerTick};

  always #5 clk = ~clk;

  // Clk edges since the reset edge of each instance.
  always @(posedge clk) begin
    na <= res_a ? 0 : na + 1;
    nb <= res_b ? 0 : nb + 1;
  end

  // Expected outputs n clk after the reset edge, from slot/line arithmetic.
  function automatic obs_t expect_at(geom_t g, int n);
    int div, ha, hfp, hbp, va, vfp, vbp, hb, vb, ht, vt, slot, xi, yi, px, py;
    bit tk, ptk;
    obs_t o;
    div = g.div; ha = g.ha; hfp = g.hfp; hbp = g.hbp;
    va = g.va; vfp = g.vfp; vbp = g.vbp;
    hb = g.hfp + g.hsw + g.hbp;
    vb = g.vfp + g.vsw + g.vbp;
    ht = ha + hb;
    vt = va + vb;
    slot = n / div;
    tk = (n % div) == div - 1;
    xi = slot % ht - hb;
    yi = (slot / ht) % vt - vb;
    o.x  = 11'(xi);
    o.y  = 11'(yi);
    o.pe = tk && xi >= 0 && yi >= 0;
    o.ls = tk && xi == -hb;
    o.fs = o.ls && yi == -vb;
    o.hs = !(xi >= hfp - hb && xi < -hbp);
    o.vs = !(yi >= vfp - vb && yi < -vbp);
    o.vb = yi < 0;
    o.tt = 1'b0;
    if (TT_PER_FRAME == 1 && n > 0) begin
      slot = (n - 1) / div;
      ptk = ((n - 1) % div) == div - 1;
      px = slot % ht - hb;
      py = (slot / ht) % vt - vb;
      o.tt = ptk && px == -hb && py == 0;
    end
    return o;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t e;
    res_a = 1'b1;
    res_b = 1'b1;
    step();
    step();
    res_a = 1'b0;
    res_b = 1'b0;
    e = '{x: 11'h760, y: 11'h7D3, pe: 1'b0, ls: 1'b0, fs: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b1, tt: 1'b0};
    checks++;
    if (got_a !== e) begin
      failures++; $display("FAIL reset_state_a got=%h exp=%h", got_a, e);
    end
    e = expect_at(gb, 0);
    checks++;
    if (got_b !== e) begin
      failures++; $display("FAIL reset_state_b got=%h exp=%h", got_b, e);
    end
    step();
    checks++;
    if (a_if.lineStart !== 1'b1 || a_if.frameStart !== 1'b1) begin
      failures++; $display("FAIL first_tick_strobes ls=%b fs=%b exp=1 1", a_if.lineStart, a_if.frameStart);
    end
    checks++;
    if (a_if.pixelX !== 11'h760 || a_if.pixelY !== 11'h7D3) begin
      failures++; $display("FAIL first_tick_coords x=%h y=%h exp=760 7d3", a_if.pixelX, a_if.pixelY);
    end
    checks++;
    if (a_if.hsync !== 1'b1 || a_if.vsync !== 1'b1) begin
      failures++; $display("FAIL first_tick_sync hs=%b vs=%b exp=1 1", a_if.hsync, a_if.vsync);
    end
  endtask

  task automatic test_line_timing();
    int ls_at[$];
    int hs_low = 0;
    int pe_cnt = 0;
    logic [10:0] fall_x = '0;
    logic prev_hs = 1'b1;
    bit bad = 1'b0;
    for (int i = 0; i < 2 * 1600 + 1; i++) begin
      if (!bad) begin
        checks++;
        if (got_a !== expect_at(ga, na)) begin
          failures++; bad = 1'b1;
          $display("FAIL line_model_a n=%0d got=%h exp=%h", na, got_a, expect_at(ga, na));
        end
      end
      if (a_if.lineStart) ls_at.push_back(na);
      if (i < 1600 && !a_if.hsync) hs_low++;
      if (prev_hs && !a_if.hsync) fall_x = a_if.pixelX;
      prev_hs = a_if.hsync;
      if (a_if.pixelEnable) pe_cnt++;
      step();
    end
    checks++;
    if (ls_at.size() != 3) begin
      failures++; $display("FAIL line_start_count got=%0d exp=3", ls_at.size());
    end else begin
      checks++;
      if (ls_at[1] - ls_at[0] != 1600 || ls_at[2] - ls_at[1] != 1600) begin
        failures++;
        $display("FAIL line_period got=%0d,%0d exp=1600", ls_at[1] - ls_at[0], ls_at[2] - ls_at[1]);
      end
    end
    checks++;
    if (hs_low != 192) begin
      failures++; $display("FAIL hsync_low_clk got=%0d exp=192", hs_low);
    end
    checks++;
    if (fall_x !== 11'h770) begin
      failures++; $display("FAIL hsync_start_x got=%h exp=770", fall_x);
    end
    checks++;
    if (pe_cnt != 0) begin
      failures++; $display("FAIL blank_line_pixel_enable got=%0d exp=0", pe_cnt);
    end
  endtask

  task automatic test_prefetch();
    int held = 0;
    int pe_during = 0;
    for (int i = 0; i < 1600; i++) begin
      if (a_if.pixelX === 11'h7FC) begin
        held++;
        if (a_if.pixelEnable) pe_during++;
      end
      step();
    end
    checks++;
    if (held != 2) begin
      failures++; $display("FAIL prefetch_hold got=%0d exp=2", held);
    end
    checks++;
    if (pe_during != 0) begin
      failures++; $display("FAIL prefetch_pixel_enable got=%0d exp=0", pe_during);
    end
  endtask

  task automatic test_mid_line_reset();
    bit found = 1'b0;
    bit bad = 1'b0;
    for (int i = 0; i < 1700 && !found; i++) begin
      if (a_if.pixelX === 11'd300) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reach_x300 got=%h exp=12c", a_if.pixelX);
    end
    res_a = 1'b1;
    step();
    res_a = 1'b0;
    checks++;
    if (got_a !== expect_at(ga, 0) || a_if.pixelEnable !== 1'b0) begin
      failures++; $display("FAIL mid_line_reset got=%h exp=%h", got_a, expect_at(ga, 0));
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (!bad) begin
        checks++;
        if (got_a !== expect_at(ga, na)) begin
          failures++; bad = 1'b1;
          $display("FAIL after_reset_a n=%0d got=%h exp=%h", na, got_a, expect_at(ga, na));
        end
      end
    end
  endtask

  task automatic test_small_frames();
    int fs_at[$];
    int vs_low = 0, vb_high = 0, pe_total = 0, runs = 0, bad_runs = 0, cur = 0, tt_cnt = 0;
    bit bad = 1'b0;
    res_b = 1'b1;
    step();
    res_b = 1'b0;
    for (int i = 0; i < 3 * B_FRAME; i++) begin
      if (!bad) begin
        checks++;
        if (got_b !== expect_at(gb, nb)) begin
          failures++; bad = 1'b1;
          $display("FAIL frame_model_b n=%0d got=%h exp=%h", nb, got_b, expect_at(gb, nb));
        end
      end
      if (b_if.frameStart) fs_at.push_back(nb);
      if (!b_if.vsync) vs_low++;
      if (b_if.vblank) vb_high++;
      if (b_if.timerTick) tt_cnt++;
      if (b_if.pixelEnable) begin
        pe_total++; cur++;
      end else if (cur > 0) begin
        runs++;
        if (cur != B_HA) bad_runs++;
        cur = 0;
      end
      step();
    end
    if (cur > 0) begin
      runs++;
      if (cur != B_HA) bad_runs++;
    end
    checks++;
    if (fs_at.size() != 3 || fs_at[1] - fs_at[0] != B_FRAME || fs_at[2] - fs_at[1] != B_FRAME) begin
      failures++; $display("FAIL frame_period starts=%0d exp=3 at period %0d", fs_at.size(), B_FRAME);
    end
    checks++;
    if (vs_low != 3 * B_VS * B_HT) begin
      failures++; $display("FAIL vsync_low_clk got=%0d exp=%0d", vs_low, 3 * B_VS * B_HT);
    end
    checks++;
    if (vb_high != 3 * (B_VT - B_VA) * B_HT) begin
      failures++; $display("FAIL vblank_clk got=%0d exp=%0d", vb_high, 3 * (B_VT - B_VA) * B_HT);
    end
    checks++;
    if (runs != 3 * B_VA || bad_runs != 0 || pe_total != 3 * B_VA * B_HA) begin
      failures++; $display("FAIL pixel_runs runs=%0d bad=%0d total=%0d exp=%0d 0 %0d",
                           runs, bad_runs, pe_total, 3 * B_VA, 3 * B_VA * B_HA);
    end
    checks++;
    if (tt_cnt != 3 * TT_PER_FRAME) begin
      failures++; $display("FAIL timer_tick_count got=%0d exp=%0d", tt_cnt, 3 * TT_PER_FRAME);
    end
  endtask

  task automatic test_wrap();
    bit found = 1'b0;
    for (int i = 0; i < 2 * B_FRAME && !found; i++) begin
      if (b_if.pixelX === 11'(B_HA - 1) && b_if.pixelY === 11'(B_VA - 1)) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reach_frame_end got=%h,%h exp=%h,%h", b_if.pixelX, b_if.pixelY,
                           11'(B_HA - 1), 11'(B_VA - 1));
    end
    step();
    checks++;
    if (b_if.pixelX !== 11'h7F7 || b_if.pixelY !== 11'h7F9 || b_if.frameStart !== 1'b1) begin
      failures++; $display("FAIL frame_wrap x=%h y=%h fs=%b exp=7f7 7f9 1",
                           b_if.pixelX, b_if.pixelY, b_if.frameStart);
    end
    found = 1'b0;
    for (int i = 0; i < 2 * B_FRAME && !found; i++) begin
      if (b_if.pixelX === 11'(B_HA - 1) && b_if.pixelY === 11'd0) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reach_line0_end got=%h,%h exp=%h,000", b_if.pixelX, b_if.pixelY,
                           11'(B_HA - 1));
    end
    step();
    checks++;
    if (b_if.pixelX !== 11'h7F7 || b_if.pixelY !== 11'd1 || b_if.lineStart !== 1'b1) begin
      failures++; $display("FAIL line_wrap x=%h y=%h ls=%b exp=7f7 001 1",
                           b_if.pixelX, b_if.pixelY, b_if.lineStart);
    end
  endtask

  task automatic test_mid_frame_reset();
    bit found = 1'b0;
    bit bad = 1'b0;
    for (int i = 0; i < 2 * B_FRAME && !found; i++) begin
      if (b_if.pixelX === 11'd5 && b_if.pixelY === 11'd2) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reach_mid_frame got=%h,%h exp=005,002", b_if.pixelX, b_if.pixelY);
    end
    res_b = 1'b1;
    step();
    res_b = 1'b0;
    checks++;
    if (b_if.pixelX !== 11'h7F7 || b_if.pixelY !== 11'h7F9 || b_if.hsync !== 1'b1 ||
        b_if.vsync !== 1'b1 || b_if.pixelEnable !== 1'b0 || b_if.timerTick !== 1'b0) begin
      failures++; $display("FAIL mid_frame_reset got=%h exp x=7f7 y=7f9 hs=1 vs=1 pe=0 tt=0", got_b);
    end
    for (int i = 0; i < 30; i++) begin
      if (!bad) begin
        checks++;
        if (got_b !== expect_at(gb, nb)) begin
          failures++; bad = 1'b1;
          $display("FAIL after_reset_b n=%0d got=%h exp=%h", nb, got_b, expect_at(gb, nb));
        end
      end
      step();
    end
  endtask

  task automatic test_timer_tick();
    int pulses = 0;
    int first_n = -1;
    logic [10:0] prev_x = '0;
    logic [10:0] prev_y = '0;
    logic [21:0] at_pulse = '0;
    for (int i = 0; i < B_FRAME; i++) begin
      if (b_if.timerTick) begin
        pulses++;
        if (first_n < 0) begin
          first_n = nb;
          at_pulse = {prev_x, prev_y};
        end
      end
      prev_x = b_if.pixelX;
      prev_y = b_if.pixelY;
      step();
    end
    checks++;
    if (pulses != TT_PER_FRAME) begin
      failures++; $display("FAIL timer_tick_pulses got=%0d exp=%0d", pulses, TT_PER_FRAME);
    end
    if (pulses > 0) begin
      checks++;
      if (first_n != (B_VT - B_VA) * B_HT * B_DIV + 1 || at_pulse !== {11'h7F7, 11'd0}) begin
        failures++; $display("FAIL timer_tick_position n=%0d prev=%h exp n=%0d prev=%h",
                             first_n, at_pulse, (B_VT - B_VA) * B_HT * B_DIV + 1, {11'h7F7, 11'd0});
      end
    end
  endtask

  initial begin
    ga = '{div: 2, ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33};
    gb = '{div: B_DIV, ha: B_HA, hfp: B_HFP, hsw: B_HS, hbp: B_HBP,
           va: B_VA, vfp: B_VFP, vsw: B_VS, vbp: B_VBP};
    test_reset();
    test_line_timing();
    test_prefetch();
    test_mid_line_reset();
    test_small_frames();
    test_wrap();
    test_mid_frame_reset();
    test_timer_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end
endmodule
